// File: rtl/pulse_capture_writer.sv
// ============================================================================
// pulse_capture_writer : measures sig_in high/low widths, packs them into RAM
// words via the arbiter write port. Optional feature macro: CAP_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pulse_capture_writer #(
   parameter int W_ADDR      = 12,
   parameter int W_DATA      = 128,
   parameter int W_CNT       = 16,
   parameter int BASE_ADDR   = 0,
   parameter int MAX_WIDTHS  = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              cap_en,
   input  logic              sig_in,
   output logic [W_ADDR-1:0] custom_wr_addr,
   output logic [W_DATA-1:0] custom_wr_data,
   output logic              custom_wr_en,
   output logic              cap_busy,
   output logic              cap_done,
   output logic [W_CNT-1:0]  cap_count
);

   localparam int LANES = W_DATA / W_CNT;
   localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);
   localparam logic [W_ADDR-1:0] BASE_A   = W_ADDR'(BASE_ADDR);
   localparam logic [W_CNT-1:0]  MAX_M1   = W_CNT'(MAX_WIDTHS - 1);

   generate
      if ((W_DATA % W_CNT) != 0 || MAX_WIDTHS < 1 || TIMEOUT_CYC < 1) begin : g_cfg_check
         $error("pulse_capture_writer: invalid parameter set");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_MEAS  = 3'd2,
      S_FLUSH = 3'd3,
      S_HDR   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t            state, next_state;
   logic [1:0]        r_sync;
   logic              r_sig_d, r_edge, r_rise, r_cap_en_d;
   logic [W_CNT-1:0]  r_counter, r_count;
   logic [IDX_W-1:0]  r_idx;
   logic [W_ADDR-1:0] r_word;
   logic [W_DATA-1:0] r_pack, w_packed;
   logic              w_arm, w_start, w_latch, w_flush_wr, w_hdr_wr, w_timeout;

`ifdef CAP_TIMEOUT_EN
   localparam logic [W_CNT-1:0] TO_LIM = W_CNT'(TIMEOUT_CYC);
   // The width counter doubles as the idle timer: it restarts at every edge.
   assign w_timeout = (state == S_MEAS) && !r_edge && (r_counter >= TO_LIM);
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      w_arm      = 1'b0;
      w_start    = 1'b0;
      w_latch    = 1'b0;
      w_flush_wr = 1'b0;
      w_hdr_wr   = 1'b0;
      case (state)
         S_IDLE: if (cap_en && !r_cap_en_d) begin
            w_arm      = 1'b1;
            next_state = S_ARM;
         end
         S_ARM: begin
            if (!cap_en) next_state = S_HDR;
            else if (r_rise) begin
               w_start    = 1'b1;
               next_state = S_MEAS;
            end
         end
         S_MEAS: begin
            w_latch = r_edge || w_timeout;
            if (!cap_en || w_timeout || (w_latch && r_count == MAX_M1))
               next_state = S_FLUSH;
         end
         S_FLUSH: begin
            w_flush_wr = (r_idx != '0);
            next_state = S_HDR;
         end
         S_HDR: begin
            w_hdr_wr   = 1'b1;
            next_state = S_DONE;
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      w_packed = r_pack;
      w_packed[r_idx*W_CNT +: W_CNT] = r_counter;
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         r_sync         <= '0;
         r_sig_d        <= 1'b0;
         r_edge         <= 1'b0;
         r_rise         <= 1'b0;
         r_cap_en_d     <= 1'b0;
         r_counter      <= '0;
         r_count        <= '0;
         r_idx          <= '0;
         r_word         <= '0;
         r_pack         <= '0;
         custom_wr_en   <= 1'b0;
         custom_wr_addr <= '0;
         custom_wr_data <= '0;
      end else begin
         r_sync       <= {r_sync[0], sig_in};
         r_sig_d      <= r_sync[1];
         r_edge       <= r_sync[1] ^ r_sig_d;
         r_rise       <= r_sync[1] & ~r_sig_d;
         r_cap_en_d   <= cap_en;
         custom_wr_en <= 1'b0;

         if (w_arm) begin
            r_counter <= '0;
            r_count   <= '0;
            r_idx     <= '0;
            r_word    <= '0;
            r_pack    <= '0;
         end
         if (w_start) r_counter <= W_CNT'(1);

         if (w_latch) begin
            r_counter <= W_CNT'(1);
            r_count   <= r_count + W_CNT'(1);
            if (r_idx == LAST_IDX) begin
               // Full word leaves now; pack register is free for the next edge.
               custom_wr_en   <= 1'b1;
               custom_wr_addr <= BASE_A + W_ADDR'(1) + r_word;
               custom_wr_data <= w_packed;
               r_pack         <= '0;
               r_idx          <= '0;
               r_word         <= r_word + W_ADDR'(1);
            end else begin
               r_pack <= w_packed;
               r_idx  <= r_idx + IDX_W'(1);
            end
         end else if (state == S_MEAS && r_counter != '1) begin
            r_counter <= r_counter + W_CNT'(1);
         end

         if (w_flush_wr) begin
            custom_wr_en   <= 1'b1;
            custom_wr_addr <= BASE_A + W_ADDR'(1) + r_word;
            custom_wr_data <= r_pack;
         end
         if (w_hdr_wr) begin
            custom_wr_en   <= 1'b1;
            custom_wr_addr <= BASE_A;
            custom_wr_data <= W_DATA'(r_count);
         end
      end
   end

   assign cap_busy  = (state == S_ARM) || (state == S_MEAS) ||
                      (state == S_FLUSH) || (state == S_HDR);
   assign cap_done  = (state == S_DONE);
   assign cap_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pulse_capture_writer.sv
// ============================================================================
// tb_pulse_capture_writer : directed, table-driven bench for pulse_capture_writer.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pulse_capture_writer;

`ifdef CAP_TIMEOUT_EN
   localparam int TB_TO = 50;
`else
   localparam int TB_TO = 65535;
`endif

   logic         clk_in = 1'b0;
   logic         rst_n  = 1'b0;
   logic         cap_en = 1'b0;
   logic         sig_in = 1'b0;
   logic [11:0]  custom_wr_addr;
   logic [127:0] custom_wr_data;
   logic         custom_wr_en;
   logic         cap_busy;
   logic         cap_done;
   logic [15:0]  cap_count;

   pulse_capture_writer #(
      .W_ADDR(12), .W_DATA(128), .W_CNT(16), .BASE_ADDR(0),
      .MAX_WIDTHS(16), .TIMEOUT_CYC(TB_TO)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .cap_en(cap_en), .sig_in(sig_in),
      .custom_wr_addr(custom_wr_addr), .custom_wr_data(custom_wr_data),
      .custom_wr_en(custom_wr_en), .cap_busy(cap_busy), .cap_done(cap_done),
      .cap_count(cap_count)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int          width;
      int          addr;
      int          lane;
      logic [15:0] exp;
   } vec_t;

   logic [127:0] mem [0:4095];
   int           wcnt [0:4095];
   int           nwr = 0;
   int           n_tests = 0;
   int           n_fail = 0;

   // RAM model behind the arbiter port
   always @(negedge clk_in) begin
      if (custom_wr_en) begin
         mem[custom_wr_addr]  = custom_wr_data;
         wcnt[custom_wr_addr] = wcnt[custom_wr_addr] + 1;
         nwr = nwr + 1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lane(input int a, input int l);
      logic [127:0] w;
      w = mem[a];
      return w[l*16 +: 16];
   endfunction

   task automatic level(input logic v, input int n);
      sig_in = v;
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic arm();
      level(1'b0, 6);
      cap_en = 1'b1;
      repeat (3) @(posedge clk_in);
      #1;
   endtask

   task automatic wait_done(input string name, input int bound);
      bit seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk_in);
         if (cap_done) seen = 1'b1;
      end
      check({name, "_done"}, 128'(seen), 128'd1);
      @(negedge clk_in);
      check({name, "_done_1cyc"}, 128'(cap_done), 128'd0);
      check({name, "_busy_low"}, 128'(cap_busy), 128'd0);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t t1 [16];
      int   nwr0, c1;

      t1[0]  = '{100,  1, 0, 16'h0064};
      t1[1]  = '{300,  1, 1, 16'h012c};
      t1[2]  = '{1000, 1, 2, 16'h03e8};
      t1[3]  = '{1500, 1, 3, 16'h05dc};
      t1[4]  = '{200,  1, 4, 16'h00c8};
      t1[5]  = '{50,   1, 5, 16'h0032};
      t1[6]  = '{7,    1, 6, 16'h0007};
      t1[7]  = '{3,    1, 7, 16'h0003};
      t1[8]  = '{2,    2, 0, 16'h0002};
      t1[9]  = '{1,    2, 1, 16'h0001};
      t1[10] = '{9,    2, 2, 16'h0009};
      t1[11] = '{250,  2, 3, 16'h00fa};
      t1[12] = '{4,    2, 4, 16'h0004};
      t1[13] = '{600,  2, 5, 16'h0258};
      t1[14] = '{5,    2, 6, 16'h0005};
      t1[15] = '{11,   2, 7, 16'h000b};

      // reset state
      repeat (3) @(negedge clk_in);
      check("rst_wr_en",   128'(custom_wr_en),   128'd0);
      check("rst_wr_addr", 128'(custom_wr_addr), 128'd0);
      check("rst_wr_data", custom_wr_data,       128'd0);
      check("rst_busy",    128'(cap_busy),       128'd0);
      check("rst_done",    128'(cap_done),       128'd0);
      check("rst_count",   128'(cap_count),      128'd0);
      @(posedge clk_in); #1;
      rst_n = 1'b1;

`ifndef CAP_TIMEOUT_EN
      // 1: full 16-width capture, two complete words
      nwr0 = nwr;
      arm();
      check("t1_busy_arm", 128'(cap_busy), 128'd1);
      for (int i = 0; i < 16; i++) level((i % 2 == 0) ? 1'b1 : 1'b0, t1[i].width);
      sig_in = 1'b1;
      wait_done("t1", 60);
      for (int i = 0; i < 16; i++)
         check($sformatf("t1_lane%0d", i), 128'(lane(t1[i].addr, t1[i].lane)), 128'(t1[i].exp));
      check("t1_header", mem[0], 128'h10);
      check("t1_count", 128'(cap_count), 128'd16);
      check("t1_writes", 128'(nwr - nwr0), 128'd3);
      cap_en = 1'b0;
`endif

      // 2: five widths, cap_en dropped mid-width
      nwr0 = nwr;
      arm();
      level(1'b1, 12); level(1'b0, 22); level(1'b1, 32); level(1'b0, 42); level(1'b1, 45);
      level(1'b0, 25);
      cap_en = 1'b0;
      wait_done("t2", 20);
      check("t2_word", mem[1], {16'd0, 16'd0, 16'd0, 16'd45, 16'd42, 16'd32, 16'd22, 16'd12});
      check("t2_header", mem[0], 128'd5);
      check("t2_count", 128'(cap_count), 128'd5);
      check("t2_writes", 128'(nwr - nwr0), 128'd2);

      // 3: armed, no edge, cap_en dropped
      nwr0 = nwr;
      c1   = wcnt[1];
      arm();
      repeat (5) @(posedge clk_in); #1;
      check("t3_busy_arm", 128'(cap_busy), 128'd1);
      cap_en = 1'b0;
      wait_done("t3", 20);
      check("t3_writes", 128'(nwr - nwr0), 128'd1);
      check("t3_header", mem[0], 128'd0);
      check("t3_no_data", 128'(wcnt[1] - c1), 128'd0);
      check("t3_count", 128'(cap_count), 128'd0);

`ifndef CAP_TIMEOUT_EN
      // 4: counter saturation, next width still correct
      arm();
      level(1'b1, 70000); level(1'b0, 40); level(1'b1, 10);
      cap_en = 1'b0;
      wait_done("t4", 20);
      check("t4_lane0_sat", 128'(lane(1, 0)), 128'h0ffff);
      check("t4_lane1", 128'(lane(1, 1)), 128'd40);
      check("t4_lane2", 128'(lane(1, 2)), 128'd0);
      check("t4_header", mem[0], 128'd2);
`endif

      // 5: 1-cycle widths across the lane7 -> lane0 boundary
      nwr0 = nwr;
      arm();
      for (int i = 0; i < 16; i++) level((i % 2 == 0) ? 1'b1 : 1'b0, 1);
      sig_in = 1'b1;
      wait_done("t5", 40);
      cap_en = 1'b0;
      check("t5_word1", mem[1], {8{16'd1}});
      check("t5_word2", mem[2], {8{16'd1}});
      check("t5_header", mem[0], 128'd16);
      check("t5_writes", 128'(nwr - nwr0), 128'd3);

      // 6: asynchronous reset mid-MEAS
      arm();
      level(1'b1, 10); level(1'b0, 10); level(1'b1, 8);
      check("t6_count_pre", 128'(cap_count), 128'd2);
      nwr0 = nwr;
      c1   = wcnt[0];
      #2 rst_n = 1'b0;
      #1;
      check("t6_wr_en",   128'(custom_wr_en),   128'd0);
      check("t6_wr_addr", 128'(custom_wr_addr), 128'd0);
      check("t6_wr_data", custom_wr_data,       128'd0);
      check("t6_busy",    128'(cap_busy),       128'd0);
      check("t6_done",    128'(cap_done),       128'd0);
      check("t6_count",   128'(cap_count),      128'd0);
      repeat (4) @(negedge clk_in);
      check("t6_no_writes", 128'(nwr - nwr0), 128'd0);
      check("t6_no_header", 128'(wcnt[0] - c1), 128'd0);
      cap_en = 1'b0;
      sig_in = 1'b0;
      @(posedge clk_in); #1;
      rst_n = 1'b1;

`ifdef CAP_TIMEOUT_EN
      // 7: stuck input terminated by the idle timeout
      arm();
      level(1'b1, 10); level(1'b0, 20); level(1'b1, 30);
      sig_in = 1'b0;
      wait_done("t7", 120);
      check("t7_word", mem[1], {16'd0, 16'd0, 16'd0, 16'd0, 16'd50, 16'd30, 16'd20, 16'd10});
      check("t7_header", mem[0], 128'd4);
      cap_en = 1'b0;
`endif

      repeat (3) @(posedge clk_in);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
